// File: rtl/serializer_10b_if.sv
// serializer_10b_if: word intake handshake and serial line outputs of serializer_10b.
interface serializer_10b_if;
    logic [9:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx_out;
    logic       tx_valid;
    logic       word_start;
    modport master (output data_in, valid_in, input ready_out, tx_out, tx_valid, word_start);
    modport slave (input data_in, valid_in, output ready_out, tx_out, tx_valid, word_start);
endinterface

// File: rtl/serializer_10b.sv
// serializer_10b: 10-bit LSB-first serializer with ready/valid word intake and registered line outputs.
// Define SERIALIZER_COMMA_IDLE_EN to fill idle time with alternating-disparity K28.5 commas instead of zeros.
module serializer_10b (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enb,
    serializer_10b_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t     state_q;
    logic [3:0] cnt_q;
    logic [8:0] sh_q;
    logic       tx_q;
    logic       tx_valid_q;
    logic       word_start_q;
    logic       idle_rdy;
    logic       accept;
`ifdef SERIALIZER_COMMA_IDLE_EN
    logic       rd_q;
    logic [9:0] comma;
    assign comma    = rd_q ? 10'h283 : 10'h17C;
    assign idle_rdy = cnt_q == 4'd9;
`else
    assign idle_rdy = 1'b1;
`endif
    assign bus.ready_out  = enb & (state_q == SHIFT ? cnt_q == 4'd9 : idle_rdy);
    assign accept         = bus.ready_out & bus.valid_in;
    assign bus.tx_out     = tx_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.word_start = word_start_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd9;
            sh_q         <= '0;
            tx_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            word_start_q <= 1'b0;
`ifdef SERIALIZER_COMMA_IDLE_EN
            rd_q         <= 1'b0;
`endif
        end else if (enb) begin
            if (accept) begin
                state_q      <= SHIFT;
                cnt_q        <= 4'd0;
                sh_q         <= bus.data_in[9:1];
                tx_q         <= bus.data_in[0];
                tx_valid_q   <= 1'b1;
                word_start_q <= 1'b1;
            end else if (cnt_q != 4'd9) begin
                cnt_q        <= cnt_q + 4'd1;
                sh_q         <= {1'b0, sh_q[8:1]};
                tx_q         <= sh_q[0];
                word_start_q <= 1'b0;
            end else begin
                state_q      <= IDLE;
                tx_valid_q   <= 1'b0;
                word_start_q <= 1'b0;
`ifdef SERIALIZER_COMMA_IDLE_EN
                // Disparity flips as each comma is committed; a reset mid-comma restores RD- anyway.
                cnt_q        <= 4'd0;
                sh_q         <= comma[9:1];
                tx_q         <= comma[0];
                rd_q         <= ~rd_q;
`else
                tx_q         <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serializer_10b.sv
// tb_serializer_10b: self-checking bench for serializer_10b.
module tb_serializer_10b;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enb = 1'b0;
    serializer_10b_if bus();
    serializer_10b dut (.clk(clk), .rst_n(rst_n), .enb(enb), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {logic b; logic v; logic s;} ent_t;
    int         n_cmp = 0;
    int         n_bad = 0;
    ent_t       q[$];
    ent_t       exp_e = '0;
    bit         armed = 1'b0;
    bit         rd = 1'b0;
    logic [9:0] cw;
    logic [9:0] pat;
    logic [19:0] line;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic tx, input logic txv, input logic ws);
        check({name, "_tx"}, bus.tx_out, tx);
        check({name, "_txv"}, bus.tx_valid, txv);
        check({name, "_ws"}, bus.word_start, ws);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [9:0] d);
        rst_n = r;
        enb = e;
        bus.valid_in = v;
        bus.data_in = d;
        @(negedge clk);
        #1;
    endtask

    // Line model: each accepted word or idle comma becomes ten queued line entries.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_e = '0;
            rd = 1'b0;
            armed = 1'b1;
        end else if (enb) begin
            if (q.size() == 0) begin
                if (bus.valid_in) begin
                    for (int i = 0; i < 10; i++) q.push_back('{bus.data_in[i], 1'b1, i == 0});
                end
`ifdef SERIALIZER_COMMA_IDLE_EN
                else begin
                    cw = rd ? 10'h283 : 10'h17C;
                    for (int i = 0; i < 10; i++) q.push_back('{cw[i], 1'b0, 1'b0});
                    rd = !rd;
                end
`endif
            end
            exp_e = q.size() != 0 ? q.pop_front() : '0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_tx_out", bus.tx_out, exp_e.b);
            check("m_tx_valid", bus.tx_valid, exp_e.v);
            check("m_word_start", bus.word_start, exp_e.s);
            check("m_ready_out", bus.ready_out, enb && q.size() == 0);
        end
    end

    initial begin
        drive(1'b0, 1'b1, 1'b0, 10'h0);
        drive(1'b0, 1'b1, 1'b0, 10'h0);
        lit("reset", 1'b0, 1'b0, 1'b0);
        check("reset_ready", bus.ready_out, 1'b1);
`ifdef SERIALIZER_COMMA_IDLE_EN
        line = {10'h283, 10'h17C};
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("comma", line[k], 1'b0, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b1, 10'h155);
            lit("comma_wait", line[k], 1'b0, 1'b0);
            check("comma_wait_ready", bus.ready_out, k == 9);
        end
        pat = 10'h155;
        drive(1'b1, 1'b1, 1'b1, 10'h155);
        lit("comma_word_a", 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("comma_word", pat[i], 1'b1, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 10'h0);
        lit("comma_resume_rdp", line[10], 1'b0, 1'b0);
`else
        pat = 10'h155;
        drive(1'b1, 1'b1, 1'b1, pat);
        lit("w155_a", 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("w155_bit", pat[i], 1'b1, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 10'h0);
        lit("w155_end", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 10'h3FF);
        lit("b2b_first", 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b1, 10'h000);
            lit("b2b_ones", 1'b1, 1'b1, 1'b0);
            check("b2b_ready", bus.ready_out, i == 9);
        end
        drive(1'b1, 1'b1, 1'b1, 10'h000);
        lit("b2b_second", 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("b2b_zeros", 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 10'h0);
        lit("b2b_end", 1'b0, 1'b0, 1'b0);
        pat = 10'h2CD;
        drive(1'b1, 1'b1, 1'b1, pat);
        lit("stall_a", pat[0], 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("stall_pre", pat[i], 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 10'h3FF);
            lit("stall_hold", pat[3], 1'b1, 1'b0);
            check("stall_ready", bus.ready_out, 1'b0);
        end
        for (int i = 4; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("stall_post", pat[i], 1'b1, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 10'h0);
        lit("stall_end", 1'b0, 1'b0, 1'b0);
        pat = 10'h155;
        drive(1'b1, 1'b1, 1'b1, pat);
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("abort_pre", pat[i], 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        lit("abort_rst", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 10'h0F0);
        lit("abort_restart", 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 10'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 10'h0);
            lit("gap_idle", 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 10'h2CD);
        lit("gap_word_a", 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 10'h0);
`endif
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 60) != 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 2) == 0, 10'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
